// File: rtl/inst_rom_loader_pkg.sv
// Shared constants and types for the instruction ROM and its program-load port.
package inst_rom_loader_pkg;

    localparam int unsigned INST_DATA_W = 32;
    localparam int unsigned ROM_ADDR_W  = 10;

    localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Word storage: one synchronous write port and one asynchronous read port.
// Kept separate so it can be swapped for a memory macro.
module inst_mem_array #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the fetch stage with a burst program-load port.
// Fetches read combinationally; loads stream words into the array via valid/ready.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = INST_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [DATA_W-1:0] inst,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    ld_state_e         state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0]  remain, remain_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              load_we;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              addr_hit;

    // State and handshake outputs; outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            remain   <= '0;
            ld_count <= '0;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            remain   <= remain_nxt;
            ld_count <= count_nxt;
            ld_ready <= (state_nxt == LOAD);
            ld_busy  <= (state_nxt == LOAD);
            ld_done  <= (state_nxt == DONE);
        end
    end

    // Next-state and write-strobe logic.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        remain_nxt = remain;
        count_nxt  = ld_count;
        load_we    = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    count_nxt = '0;
                    if (ld_len != '0) begin
                        state_nxt  = LOAD;
                        ptr_nxt    = ld_base;
                        remain_nxt = ld_len;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    load_we    = 1'b1;
                    ptr_nxt    = ptr + ADDR_W'(1);
                    remain_nxt = remain - CNT_W'(1);
                    count_nxt  = ld_count + CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte address to word index; anything above the array returns NOP.
    assign raddr    = ADDR_W'(addr >> 2);
    assign addr_hit = ((addr >> (ADDR_W + 2)) == 32'd0);

    inst_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk  (clk),
        .we   (load_we & ~rst),
        .waddr(ptr),
        .wdata(ld_data),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign inst = (!rst && ce && (state != LOAD) && addr_hit) ? rdata : DATA_W'(ZERO_WORD);

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: read-path vector table plus load-burst sequences.
module tb_inst_rom_loader;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        ld_start;
    logic [9:0]  ld_base;
    logic [10:0] ld_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic [10:0] ld_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t     rv [7];
    logic [31:0] w1 [3];

    inst_rom_loader dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .addr    (addr),
        .inst    (inst),
        .ld_start(ld_start),
        .ld_base (ld_base),
        .ld_len  (ld_len),
        .ld_valid(ld_valid),
        .ld_data (ld_data),
        .ld_ready(ld_ready),
        .ld_busy (ld_busy),
        .ld_done (ld_done),
        .ld_count(ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [9:0] base, input logic [10:0] len);
        ld_start = 1'b1;
        ld_base  = base;
        ld_len   = len;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        ce   = 1'b1;
        addr = a;
        #1;
        chk(name, inst, exp);
        ce = 1'b0;
    endtask

    initial begin
        w1[0] = 32'h34011100;
        w1[1] = 32'h34020020;
        w1[2] = 32'h3403ff00;
        rv[0] = '{1'b1, 32'h0000_0000, 32'h34011100, "rd_w0"};
        rv[1] = '{1'b1, 32'h0000_0004, 32'h34020020, "rd_w1"};
        rv[2] = '{1'b1, 32'h0000_0008, 32'h3403ff00, "rd_w2"};
        rv[3] = '{1'b1, 32'h0000_0007, 32'h34020020, "rd_lsb_ignored"};
        rv[4] = '{1'b0, 32'h0000_0004, 32'h00000000, "rd_ce_off"};
        rv[5] = '{1'b1, 32'h0000_1000, 32'h00000000, "rd_out_of_range"};
        rv[6] = '{1'b1, 32'h8000_0000, 32'h00000000, "rd_out_of_range_hi"};

        rst = 1'b1; ce = 1'b0; addr = '0; ld_start = 1'b0; ld_base = '0;
        ld_len = '0; ld_valid = 1'b0; ld_data = '0;
        tick();
        tick();

        // Reset state
        chk("rst_inst", inst, 32'h0);
        chk("rst_ready", 32'(ld_ready), 32'h0);
        chk("rst_busy", 32'(ld_busy), 32'h0);
        chk("rst_done", 32'(ld_done), 32'h0);
        chk("rst_count", 32'(ld_count), 32'h0);
        rd("rst_inst_ce", 32'h0, 32'h0);
        rst = 1'b0;
        tick();

        // Back-to-back burst of three words at base 0
        start(10'd0, 11'd3);
        chk("b1_busy_start", 32'(ld_busy), 32'h1);
        chk("b1_ready_start", 32'(ld_ready), 32'h1);
        chk("b1_count_start", 32'(ld_count), 32'h0);
        rd("b1_nop_during_load", 32'h4, 32'h0);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = w1[i];
            tick();
            chk("b1_count", 32'(ld_count), 32'(i + 1));
            chk("b1_busy", 32'(ld_busy), (i < 2) ? 32'h1 : 32'h0);
            chk("b1_done", 32'(ld_done), (i < 2) ? 32'h0 : 32'h1);
        end
        chk("b1_ready_done", 32'(ld_ready), 32'h0);
        ld_valid = 1'b0;
        tick();
        chk("b1_done_clear", 32'(ld_done), 32'h0);
        chk("b1_count_hold", 32'(ld_count), 32'h3);

        // Read-path vector table
        for (int i = 0; i < 7; i++) begin
            ce   = rv[i].ce;
            addr = rv[i].addr;
            #1;
            chk(rv[i].name, inst, rv[i].exp);
        end
        ce = 1'b0;

        // Burst at base 4 with two idle cycles before each word
        start(10'd4, 11'd3);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b0;
            tick();
            tick();
            chk("b2_stall_count", 32'(ld_count), 32'(i));
            chk("b2_stall_busy", 32'(ld_busy), 32'h1);
            ld_valid = 1'b1;
            ld_data  = 32'hB000_0004 + 32'(i);
            tick();
            chk("b2_count", 32'(ld_count), 32'(i + 1));
            chk("b2_done", 32'(ld_done), (i < 2) ? 32'h0 : 32'h1);
        end
        ld_valid = 1'b0;
        tick();
        chk("b2_done_clear", 32'(ld_done), 32'h0);
        rd("b2_rd4", 32'h10, 32'hB000_0004);
        rd("b2_rd5", 32'h14, 32'hB000_0005);
        rd("b2_rd6", 32'h18, 32'hB000_0006);

        // Pointer wrap from the last word to word 0
        start(10'd1023, 11'd2);
        ld_valid = 1'b1;
        ld_data  = 32'hAAAA_0001;
        tick();
        ld_data  = 32'hAAAA_0002;
        tick();
        chk("wrap_done", 32'(ld_done), 32'h1);
        chk("wrap_count", 32'(ld_count), 32'h2);
        ld_valid = 1'b0;
        tick();
        rd("wrap_rd0", 32'h0, 32'hAAAA_0002);
        rd("wrap_rd1023", 32'hFFC, 32'hAAAA_0001);
        rd("wrap_rd1_untouched", 32'h4, 32'h34020020);

        // Zero-length burst: straight to DONE, no write, start in DONE ignored
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        start(10'd0, 11'd0);
        chk("len0_done", 32'(ld_done), 32'h1);
        chk("len0_busy", 32'(ld_busy), 32'h0);
        chk("len0_ready", 32'(ld_ready), 32'h0);
        chk("len0_count", 32'(ld_count), 32'h0);
        ld_start = 1'b1;
        ld_len   = 11'd5;
        tick();
        ld_start = 1'b0;
        chk("len0_done_pulse", 32'(ld_done), 32'h0);
        chk("len0_start_ignored", 32'(ld_busy), 32'h0);
        ld_valid = 1'b0;
        tick();
        chk("len0_idle_busy", 32'(ld_busy), 32'h0);
        rd("len0_no_write", 32'h0, 32'hAAAA_0002);
        rd("len0_oor", 32'h0000_1000, 32'h0);

        // Reset after the first of three words
        start(10'd0, 11'd3);
        ld_valid = 1'b1;
        ld_data  = 32'hC000_0000;
        tick();
        chk("rstmid_count1", 32'(ld_count), 32'h1);
        ld_data = 32'hC000_0001;
        rst     = 1'b1;
        tick();
        chk("rstmid_busy", 32'(ld_busy), 32'h0);
        chk("rstmid_ready", 32'(ld_ready), 32'h0);
        chk("rstmid_done", 32'(ld_done), 32'h0);
        chk("rstmid_count", 32'(ld_count), 32'h0);
        rst      = 1'b0;
        ld_valid = 1'b0;
        tick();
        chk("rstmid_no_done", 32'(ld_done), 32'h0);
        chk("rstmid_idle", 32'(ld_busy), 32'h0);
        rd("rstmid_w0_kept", 32'h0, 32'hC000_0000);
        rd("rstmid_w1_prior", 32'h4, 32'h34020020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder for the core's fetch interface (ce / addr in, inst out).
- Answers fetches combinationally from a word array, so instruction data is valid in the same cycle as the PC and is captured by the IF/ID register at the next clk edge.
- A sequential program-load port (valid/ready handshake, base/length, auto-incrementing pointer) lets a testbench or boot agent fill the array after reset without a $readmemh rebuild.

Parameters:
- ADDR_W, 10, log2 of array depth in 32-bit words (default 1024 words = 4 KiB).
- DATA_W, 32, instruction word width; must equal `Inst_Data.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  fetch enable from pc_reg (rom_ce_o).
- addr  input  32  byte address from pc (rom_addr_o).
- inst  output  DATA_W  instruction word to core (rom_data_i).
- ld_start  input  1  begin a load burst; sampled only in IDLE.
- ld_base  input  ADDR_W  first word index of burst; sampled with ld_start.
- ld_len  input  ADDR_W+1  number of words in burst (0..2^ADDR_W); sampled with ld_start.
- ld_valid  input  1  ld_data valid.
- ld_data  input  DATA_W  word to write.
- ld_ready  output  1  loader accepts a word this cycle.
- ld_busy  output  1  burst in progress; fetches return NOP.
- ld_done  output  1  one-cycle pulse at burst completion.
- ld_count  output  ADDR_W+1  words written in current/last burst.

Behaviour:
- Read path (combinational): inst = mem[addr[ADDR_W+1:2]] when rst=0, ce=1, state!=LOAD and addr[31:ADDR_W+2]==0. Otherwise inst = `ZeroWord (MIPS NOP). addr[1:0] are ignored.
- Array contents are not cleared by rst. They persist across reset, including reset mid-burst.
- FSM states: IDLE, LOAD, DONE. Reset → IDLE.
- IDLE:
  - ld_start=1 and ld_len!=0 → LOAD; ptr<=ld_base, remain<=ld_len, ld_count<=0.
  - ld_start=1 and ld_len==0 → DONE; ld_count<=0.
- LOAD:
  - ld_ready=1 and ld_busy=1.
  - On ld_valid&ld_ready: mem[ptr]<=ld_data, ptr<=ptr+1 (wraps modulo 2^ADDR_W), remain<=remain-1, ld_count<=ld_count+1.
  - If the accepting cycle has remain==1 → DONE.
  - ld_valid=0 stalls indefinitely with no timeout.
  - ld_start is ignored in LOAD.
- DONE: ld_done=1 for exactly one cycle, ld_ready=0, ld_busy=0; → IDLE unconditionally. An ld_start in DONE is ignored.
- ld_len = 2^ADDR_W: the entire array is written once, and ptr wraps back to ld_base.
- Throughput: one word per cycle; burst of N words takes N accepting cycles + 1 DONE cycle.
- Reset values: ld_ready=0, ld_busy=0, ld_done=0, ld_count=0, ptr=0, remain=0, inst=`ZeroWord.
- Reset mid-LOAD: next cycle state is IDLE. Words already written remain; no ld_done pulse is produced.
- Same-cycle write and fetch to the same word cannot occur: fetches return NOP during LOAD.
- Pipeline-order ordering vs. the core is the driver's responsibility: hold the core in reset or accept NOPs while loading.

Decomposition:
- define.v: add `RomAddrW (default ADDR_W) and `RomDepth. Reuse the existing `ZeroWord, `Inst_Data, `Inst_Addr.
- FSM state encodings are localparams in the module (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- One natural sub-module: inst_mem_array, with 1 synchronous write port (we, waddr, wdata) and 1 asynchronous read port (raddr, rdata). This isolates the storage for later replacement by a BRAM macro.

Test Plan:
- Reset then ce=0, addr=0x0 → inst=0x00000000; ld_ready=0, ld_busy=0, ld_done=0.
- ld_start with base=0, len=3; words 0x34011100, 0x34020020, 0x3403ff00 sent back-to-back with valid=1 → ld_busy high 3 cycles, ld_done pulse on 4th cycle, ld_count=3. Then ce=1, addr=0x4 → inst=0x34020020.
- Same burst with ld_valid deasserted 2 cycles between words → no extra writes, ld_count increments only on handshakes, ld_done after the 3rd accepted word.
- base=1023, len=2, data 0xAAAA0001 / 0xAAAA0002 → mem[1023]=0xAAAA0001, mem[0]=0xAAAA0002 (wrap). addr=0x0 → 0xAAAA0002.
- ld_len=0 → DONE the next cycle, ld_done=1 for one cycle, no write. Also: addr=0x00001000 (out of range) with ce=1 → inst=0.
- rst asserted after 1 of 3 words accepted → next cycle IDLE, ld_busy=0, no ld_done pulse. Word 0 is still readable; word 1 keeps its prior contents.
